// File: rtl/rf_chk_sequencer_if.sv
// Signal bundle between the checkpoint sequencer, the pipeline and the register file.
// master = pipeline / register-file side, slave = the sequencer itself.
interface rf_chk_sequencer_if #(
  parameter int name_width = 2
);
  logic                  REQ_CHK;
  logic                  REQ_CHK_READY;
  logic [name_width-1:0] CHK_ID_OUT;
  logic                  RF_CHK_E;
  logic                  RF_CHK_READY;
  logic [name_width-1:0] RF_CHK_OUT;
  logic                  RES_VALID;
  logic [name_width-1:0] RES_ID;
  logic                  RES_MISPRED;
  logic                  RES_READY;
  logic                  RF_ROLLBK_E;
  logic                  RF_DO_ROLL;
  logic                  RF_DO_REL;
  logic [name_width-1:0] RF_ROLLBK_IN;
  logic                  FLUSH;
  logic [name_width:0]   OUTSTANDING;
  logic                  ERR;

  modport master (
    output REQ_CHK, RF_CHK_READY, RF_CHK_OUT, RES_VALID, RES_ID, RES_MISPRED,
    input  REQ_CHK_READY, CHK_ID_OUT, RF_CHK_E, RES_READY, RF_ROLLBK_E, RF_DO_ROLL,
           RF_DO_REL, RF_ROLLBK_IN, FLUSH, OUTSTANDING, ERR
  );

  modport slave (
    input  REQ_CHK, RF_CHK_READY, RF_CHK_OUT, RES_VALID, RES_ID, RES_MISPRED,
    output REQ_CHK_READY, CHK_ID_OUT, RF_CHK_E, RES_READY, RF_ROLLBK_E, RF_DO_ROLL,
           RF_DO_REL, RF_ROLLBK_IN, FLUSH, OUTSTANDING, ERR
  );
endinterface

// File: rtl/rf_chk_sequencer.sv
// Checkpoint lifecycle sequencer: in-order allocation, out-of-order resolution, oldest-first release,
// one-cycle combined rollback+release then a DRAIN window. Define CHK_SEQ_ERR_EN to build the ERR checker.
module rf_chk_sequencer #(
  parameter int name_width   = 2,
  parameter int depth        = 2**name_width,
  parameter int flush_cycles = 2
) (
  input  logic              CLK,
  input  logic              RST,
  rf_chk_sequencer_if.slave bus
);
  localparam int ptr_w = name_width + 1;
  localparam int cnt_w = (flush_cycles > 0) ? $clog2(flush_cycles + 1) : 1;
  localparam logic [ptr_w-1:0] depth_p   = ptr_w'(depth);
  localparam logic [ptr_w-1:0] ptr_one   = {{name_width{1'b0}}, 1'b1};
  localparam logic [cnt_w-1:0] flush_p   = cnt_w'(flush_cycles);
  localparam logic [cnt_w-1:0] drain_one = {{(cnt_w-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {RUN = 2'd0, ROLL = 2'd1, DRAIN = 2'd2} state_t;

  state_t                state_r, state_nxt_s;
  logic [ptr_w-1:0]      head_r, tail_r, head_nxt_s, tail_nxt_s, span_s;
  logic [depth-1:0]      valid_r, resolved_r, valid_nxt_s, resolved_nxt_s, squash_s;
  logic [name_width-1:0] roll_id_r, roll_id_nxt_s, head_idx_s, tail_idx_s;
  logic [cnt_w-1:0]      drain_cnt_r, drain_cnt_nxt_s;
  logic [name_width:0]   outstanding_r;
  logic                  chk_ready_s, grant_s, res_accept_s, res_live_s;
  logic                  rb_e_s, do_roll_s, do_rel_s, flush_s;
  logic [name_width-1:0] rb_id_s;

  function automatic logic [name_width:0] popcount(input logic [depth-1:0] v);
    logic [name_width:0] n;
    n = '0;
    for (int i = 0; i < depth; i++) n = n + {{name_width{1'b0}}, v[i]};
    return n;
  endfunction

  // Entries from the rolled-back ID up to tail-1, measured as age offsets from head.
  function automatic logic [depth-1:0] squash_mask(input logic [name_width-1:0] h,
                                                   input logic [name_width-1:0] r,
                                                   input logic [ptr_w-1:0]      span);
    logic [depth-1:0]      m;
    logic [name_width-1:0] off, roff;
    m    = '0;
    roff = r - h;
    for (int i = 0; i < depth; i++) begin
      off  = name_width'(i) - h;
      m[i] = ({1'b0, off} >= {1'b0, roff}) && ({1'b0, off} < span);
    end
    return m;
  endfunction

  assign span_s       = tail_r - head_r;
  assign head_idx_s   = head_r[name_width-1:0];
  assign tail_idx_s   = tail_r[name_width-1:0];
  assign squash_s     = squash_mask(head_idx_s, roll_id_r, span_s);
  assign chk_ready_s  = (state_r == RUN) && bus.RF_CHK_READY && (span_s < depth_p) &&
                        !valid_r[tail_idx_s] && !(bus.RES_VALID && bus.RES_MISPRED);
  assign grant_s      = bus.REQ_CHK && chk_ready_s;
  assign res_accept_s = bus.RES_VALID && (state_r == RUN);
  assign res_live_s   = valid_r[bus.RES_ID] && !resolved_r[bus.RES_ID];

  assign bus.REQ_CHK_READY = chk_ready_s;
  assign bus.RF_CHK_E      = grant_s;
  assign bus.CHK_ID_OUT    = bus.RF_CHK_OUT;
  assign bus.RES_READY     = (state_r == RUN);
  assign bus.RF_ROLLBK_E   = rb_e_s;
  assign bus.RF_DO_ROLL    = do_roll_s;
  assign bus.RF_DO_REL     = do_rel_s;
  assign bus.RF_ROLLBK_IN  = rb_id_s;
  assign bus.FLUSH         = flush_s;
  assign bus.OUTSTANDING   = outstanding_r;

  // Next-state, table updates and rollback-port outputs.
  always_comb begin
    state_nxt_s     = state_r;
    head_nxt_s      = head_r;
    tail_nxt_s      = tail_r;
    valid_nxt_s     = valid_r;
    resolved_nxt_s  = resolved_r;
    roll_id_nxt_s   = roll_id_r;
    drain_cnt_nxt_s = drain_cnt_r;
    rb_e_s          = 1'b0;
    do_roll_s       = 1'b0;
    do_rel_s        = 1'b0;
    flush_s         = 1'b0;
    rb_id_s         = head_idx_s;
    case (state_r)
      RUN: begin
        if ((span_s != '0) && valid_r[head_idx_s] && resolved_r[head_idx_s]) begin
          rb_e_s                  = 1'b1;
          do_rel_s                = 1'b1;
          valid_nxt_s[head_idx_s] = 1'b0;
          head_nxt_s              = head_r + ptr_one;
        end else if ((span_s != '0) && !valid_r[head_idx_s]) begin
          head_nxt_s = head_r + ptr_one;
        end else begin
          head_nxt_s = head_r;
        end
        // Grant and resolution never touch the same ID: one needs !valid, the other valid.
        if (grant_s) begin
          valid_nxt_s[tail_idx_s]    = 1'b1;
          resolved_nxt_s[tail_idx_s] = 1'b0;
          tail_nxt_s                 = tail_r + ptr_one;
        end else begin
          tail_nxt_s = tail_r;
        end
        if (res_accept_s && res_live_s && bus.RES_MISPRED) begin
          roll_id_nxt_s = bus.RES_ID;
          state_nxt_s   = ROLL;
        end else if (res_accept_s && res_live_s) begin
          resolved_nxt_s[bus.RES_ID] = 1'b1;
        end else begin
          roll_id_nxt_s = roll_id_r;
        end
      end
      ROLL: begin
        rb_e_s          = 1'b1;
        do_roll_s       = 1'b1;
        do_rel_s        = 1'b1;
        flush_s         = 1'b1;
        rb_id_s         = roll_id_r;
        valid_nxt_s     = valid_r & ~squash_s;
        drain_cnt_nxt_s = flush_p;
        state_nxt_s     = (flush_cycles == 0) ? RUN : DRAIN;
      end
      DRAIN: begin
        if (drain_cnt_r > drain_one) begin
          drain_cnt_nxt_s = drain_cnt_r - drain_one;
        end else begin
          drain_cnt_nxt_s = '0;
          state_nxt_s     = RUN;
        end
      end
      default: begin
        state_nxt_s = RUN;
      end
    endcase
  end

  // State, pointer and table registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r       <= RUN;
      head_r        <= '0;
      tail_r        <= '0;
      valid_r       <= '0;
      resolved_r    <= '0;
      roll_id_r     <= '0;
      drain_cnt_r   <= '0;
      outstanding_r <= '0;
    end else begin
      state_r       <= state_nxt_s;
      head_r        <= head_nxt_s;
      tail_r        <= tail_nxt_s;
      valid_r       <= valid_nxt_s;
      resolved_r    <= resolved_nxt_s;
      roll_id_r     <= roll_id_nxt_s;
      drain_cnt_r   <= drain_cnt_nxt_s;
      outstanding_r <= popcount(valid_nxt_s);
    end
  end

`ifdef CHK_SEQ_ERR_EN
  logic err_r, err_hit_s;
  assign err_hit_s = (grant_s && (bus.RF_CHK_OUT != tail_idx_s)) ||
                     (res_accept_s && valid_r[bus.RES_ID] && resolved_r[bus.RES_ID]) ||
                     (!bus.RF_CHK_READY && !valid_r[tail_idx_s] && (span_s < depth_p));

  // Sticky protocol-error flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      err_r <= 1'b0;
    end else if (err_hit_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end
  assign bus.ERR = err_r;
`else
  assign bus.ERR = 1'b0;
`endif
endmodule
